// File: rtl/expr_pkg.sv
// Shared constants for the expression evaluator: ASCII codes of the accepted
// characters and the parser state encoding.
package expr_pkg;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;
  localparam logic [7:0] CH_EQ   = 8'h3D;
  localparam logic [7:0] CH_SP   = 8'h20;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP   = 2'd1,
    S_DIG  = 2'd2,
    S_ERR  = 2'd3
  } state_t;

endpackage

// File: rtl/expr_eval_char_class.sv
// Combinational character classifier: decodes one ASCII byte into the token
// classes the evaluator's state machine consumes.
module char_class
  import expr_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_digit,
  output logic [3:0] dval,
  output logic       is_plus,
  output logic       is_mul,
  output logic       is_eq,
  output logic       is_space
);

  always_comb begin
    is_digit = (ch >= CH_0) && (ch <= CH_9);
    // Digits 0x30..0x39 carry their value in the low nibble.
    dval     = is_digit ? ch[3:0] : 4'd0;
    is_plus  = (ch == CH_PLUS);
    is_mul   = (ch == CH_MUL);
    is_eq    = (ch == CH_EQ);
    is_space = (ch == CH_SP);
  end

endmodule

// File: rtl/expr_eval.sv
// Evaluates single-digit '+'/'*' expressions terminated by '=', with '*'
// binding tighter than '+'; reports the modulo-2^W result or a syntax error.
module expr_eval
  import expr_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         in_valid,
  input  logic [7:0]   in,
  output logic [W-1:0] result,
  output logic         result_valid,
  output logic         ovf,
  output logic         err
);

  logic       is_digit, is_plus, is_mul, is_eq, is_space;
  logic [3:0] dval;

  char_class u_class (
    .ch       (in),
    .is_digit (is_digit),
    .dval     (dval),
    .is_plus  (is_plus),
    .is_mul   (is_mul),
    .is_eq    (is_eq),
    .is_space (is_space)
  );

  // MSB of the returned value flags a wrap of the W-bit result.
  function automatic logic [W:0] add_wrap(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [W:0] mul_wrap(input logic [W-1:0] a, input logic [3:0] b);
    logic [W+3:0] p;
    p = {4'b0000, a} * {{W{1'b0}}, b};
    return {|p[W+3:W], p[W-1:0]};
  endfunction

  state_t       state;
  logic [W-1:0] sum, term;
  logic         pend_mul, ovf_acc;
  logic [W:0]   sum_next, prod_next;
  logic [W-1:0] dval_ext;

  assign dval_ext  = W'(dval);
  assign sum_next  = add_wrap(sum, term);
  assign prod_next = mul_wrap(term, dval);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state        <= S_IDLE;
      sum          <= '0;
      term         <= '0;
      pend_mul     <= 1'b0;
      ovf_acc      <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      ovf          <= 1'b0;
      err          <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      err          <= 1'b0;
      if (in_valid && !is_space) begin
        unique case (state)
          S_IDLE: begin
            if (is_digit) begin
              term    <= dval_ext;
              sum     <= '0;
              ovf_acc <= 1'b0;
              state   <= S_OP;
            end else if (is_eq) begin
              err <= 1'b1;
            end else begin
              state <= S_ERR;
            end
          end
          S_OP: begin
            if (is_plus) begin
              sum      <= sum_next[W-1:0];
              ovf_acc  <= ovf_acc | sum_next[W];
              pend_mul <= 1'b0;
              state    <= S_DIG;
            end else if (is_mul) begin
              pend_mul <= 1'b1;
              state    <= S_DIG;
            end else if (is_eq) begin
              result       <= sum_next[W-1:0];
              result_valid <= 1'b1;
              ovf          <= ovf_acc | sum_next[W];
              state        <= S_IDLE;
            end else begin
              state <= S_ERR;
            end
          end
          S_DIG: begin
            if (is_digit) begin
              if (pend_mul) begin
                term    <= prod_next[W-1:0];
                ovf_acc <= ovf_acc | prod_next[W];
              end else begin
                term <= dval_ext;
              end
              state <= S_OP;
            end else if (is_eq) begin
              err   <= 1'b1;
              state <= S_IDLE;
            end else begin
              state <= S_ERR;
            end
          end
          S_ERR: begin
            if (is_eq) begin
              err   <= 1'b1;
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_expr_eval.sv
// Bench for expr_eval: W=16 and W=8 instances share one input stream and are
// checked each cycle against a string-level expression evaluator.
module tb_expr_eval;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_ch = 8'h00;

  logic [15:0] result16;
  logic        rv16, ovf16, err16;
  logic [7:0]  result8;
  logic        rv8, ovf8, err8;

  int checks = 0;
  int failures = 0;

  expr_eval #(.W(16)) dut16 (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in(in_ch),
    .result(result16), .result_valid(rv16), .ovf(ovf16), .err(err16)
  );

  expr_eval #(.W(8)) dut8 (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in(in_ch),
    .result(result8), .result_valid(rv8), .ovf(ovf8), .err(err8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: collect the characters of one expression, then evaluate the
  // whole string on '='. Legal form is digit (op digit)*.
  logic [7:0] buffer[$];
  logic [15:0] e_res16;
  logic [7:0]  e_res8;
  logic e_rv16, e_ovf16, e_err16, e_rv8, e_ovf8, e_err8;

  function automatic void evaluate(input logic [7:0] b[$], input int w,
                                   output logic ok, output longint res, output logic ov);
    longint mask, sum, term, d;
    mask = (64'd1 << w) - 1;
    ok = (b.size() % 2 == 1);
    for (int i = 0; i < b.size(); i++) begin
      if (i % 2 == 0) begin
        if (b[i] < 8'h30 || b[i] > 8'h39) ok = 1'b0;
      end else begin
        if (b[i] != 8'h2B && b[i] != 8'h2A) ok = 1'b0;
      end
    end
    res = 0;
    ov = 1'b0;
    if (!ok) return;
    sum = 0;
    term = longint'(b[0]) - 48;
    for (int i = 1; i < b.size(); i += 2) begin
      d = longint'(b[i+1]) - 48;
      if (b[i] == 8'h2A) begin
        term = term * d;
        if (term > mask) ov = 1'b1;
        term = term & mask;
      end else begin
        sum = sum + term;
        if (sum > mask) ov = 1'b1;
        sum = sum & mask;
        term = d;
      end
    end
    sum = sum + term;
    if (sum > mask) ov = 1'b1;
    res = sum & mask;
  endfunction

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      buffer.delete();
      e_res16 = '0; e_rv16 = 1'b0; e_ovf16 = 1'b0; e_err16 = 1'b0;
      e_res8  = '0; e_rv8  = 1'b0; e_ovf8  = 1'b0; e_err8  = 1'b0;
    end else begin
      logic ok;
      longint r;
      logic ov;
      e_rv16 = 1'b0; e_err16 = 1'b0; e_rv8 = 1'b0; e_err8 = 1'b0;
      if (in_valid && in_ch != 8'h20) begin
        if (in_ch == 8'h3D) begin
          evaluate(buffer, 16, ok, r, ov);
          if (ok) begin e_res16 = r[15:0]; e_rv16 = 1'b1; e_ovf16 = ov; end
          else e_err16 = 1'b1;
          evaluate(buffer, 8, ok, r, ov);
          if (ok) begin e_res8 = r[7:0]; e_rv8 = 1'b1; e_ovf8 = ov; end
          else e_err8 = 1'b1;
          buffer.delete();
        end else begin
          buffer.push_back(in_ch);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_result16", 64'(result16), 64'(e_res16));
    chk("cmp_rv16", 64'(rv16), 64'(e_rv16));
    chk("cmp_err16", 64'(err16), 64'(e_err16));
    if (e_rv16) chk("cmp_ovf16", 64'(ovf16), 64'(e_ovf16));
    chk("cmp_result8", 64'(result8), 64'(e_res8));
    chk("cmp_rv8", 64'(rv8), 64'(e_rv8));
    chk("cmp_err8", 64'(err8), 64'(e_err8));
    if (e_rv8) chk("cmp_ovf8", 64'(ovf8), 64'(e_ovf8));
  end

  // Each character is held for one cycle; returns #1 after the edge that
  // sampled the last one, so '=' outcomes are already visible.
  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      in_valid = 1'b1;
      in_ch = s[i];
      @(posedge clk); #1;
    end
  endtask

  task automatic send_rand(input string s);
    for (int i = 0; i < s.len(); i++) begin
      if ($urandom_range(3) == 0) begin
        in_valid = 1'b0;
        in_ch = 8'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_ch = s[i];
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    string s;
    string pool;
    int nops, pos;
    pool = "+*=x 05";

    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", 64'(result16), 64'd0);
    chk("reset_rv", 64'(rv16), 64'd0);
    chk("reset_err", 64'(err16), 64'd0);
    chk("reset_ovf", 64'(ovf16), 64'd0);
    clr_n = 1'b1;

    send("1+2*3=");
    chk("t1_result", 64'(result16), 64'd7);
    chk("t1_rv", 64'(rv16), 64'd1);
    chk("t1_ovf", 64'(ovf16), 64'd0);
    chk("t1_err", 64'(err16), 64'd0);

    send("2*3+4*5=");
    chk("t2_result_a", 64'(result16), 64'd26);
    chk("t2_rv_a", 64'(rv16), 64'd1);
    send("9=");
    chk("t2_result_b", 64'(result16), 64'd9);
    chk("t2_rv_b", 64'(rv16), 64'd1);
    chk("t2_err_b", 64'(err16), 64'd0);

    send("1++2=");
    chk("t3_err_a", 64'(err16), 64'd1);
    chk("t3_rv_a", 64'(rv16), 64'd0);
    chk("t3_hold", 64'(result16), 64'd9);
    send("12+3=");
    chk("t3_err_b", 64'(err16), 64'd1);
    send("+=");
    chk("t3_err_c", 64'(err16), 64'd1);
    send("=");
    chk("t3_err_d", 64'(err16), 64'd1);
    idle(1);
    chk("t3_err_clear", 64'(err16), 64'd0);

    send("9*9*9*9=");
    chk("t4_result8", 64'(result8), 64'd161);
    chk("t4_ovf8", 64'(ovf8), 64'd1);
    chk("t4_result16", 64'(result16), 64'd6561);
    chk("t4_ovf16", 64'(ovf16), 64'd0);
    send("1+1=");
    chk("t4_result8_b", 64'(result8), 64'd2);
    chk("t4_ovf8_b", 64'(ovf8), 64'd0);

    send("1");
    in_valid = 1'b0;
    in_ch = 8'h3D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_gap_rv", 64'(rv16), 64'd0);
    chk("t5_gap_err", 64'(err16), 64'd0);
    send(" + 2=");
    chk("t5_result", 64'(result16), 64'd3);
    chk("t5_rv", 64'(rv16), 64'd1);

    send("7=");
    send("3*4");
    in_valid = 1'b0;
    #2 clr_n = 1'b0;
    #1;
    chk("t6_async_result", 64'(result16), 64'd0);
    chk("t6_async_result8", 64'(result8), 64'd0);
    @(posedge clk); #1;
    clr_n = 1'b1;
    send("5=");
    chk("t6_result", 64'(result16), 64'd5);
    chk("t6_rv", 64'(rv16), 64'd1);

    for (int n = 0; n < 400; n++) begin
      nops = $urandom_range(0, 5);
      s = "";
      s = {s, string'(8'(8'h30 + $urandom_range(9)))};
      for (int k = 0; k < nops; k++) begin
        s = {s, ($urandom_range(1) != 0) ? "*" : "+"};
        if ($urandom_range(4) == 0) s = {s, " "};
        s = {s, string'(8'(8'h30 + $urandom_range(9)))};
      end
      if ($urandom_range(7) == 0) begin
        pos = $urandom_range(s.len() - 1);
        s[pos] = pool[$urandom_range(pool.len() - 1)];
      end
      s = {s, "="};
      send_rand(s);
      if ($urandom_range(2) == 0) idle($urandom_range(1, 2));
    end

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
